// File: rtl/iq_issue_sel.sv
// ---------------------------------------------------------------------------
// iq_issue_sel
//
// In-order multi-issue selector that sits directly behind the instruction
// queue. Every cycle it looks at the head entries the queue presents, checks
// their operands against a latency-countdown scoreboard, and issues the
// longest ready in-order prefix (up to ISSUE_WIDTH) into a registered issue
// stage that feeds execute. The queue is told how many entries were taken
// through the extract handshake (strobe plus count-minus-one).
//
// Ports:
//   clock, reset_n       sole clock, asynchronous active-low reset
//   ext_valid[i]         head slot i holds a valid entry
//   ent[i]               head slot payload (opaque type T)
//   src_a/src_b[i]       source registers of slot i
//   dst[i], dst_we[i]    destination register of slot i and its write enable
//   lat[i]               cycles until slot i's result is forwardable (0 = next)
//   ext_enable           extract strobe to the queue (combinational)
//   ext_consumed         number of issued entries minus one (combinational)
//   exec_stall           execute cannot accept a new group this cycle
//   flush                pipeline flush
//   iss_valid[k]         registered issue lane valid
//   iss_ent[k]           registered issue lane payload
//
// Optional feature (macro ISSUE_STATS_EN):
//   When defined, adds saturating 32-bit counters stat_issued, stat_dep_stall
//   and stat_exec_stall as outputs. Functional behaviour is unchanged.
// ---------------------------------------------------------------------------
module iq_issue_sel #(
    parameter type T            = logic [31:0],
    parameter int  EXT_COUNT    = 4,
    parameter int  ISSUE_WIDTH  = 4,
    parameter int  NREGS        = 32,
    parameter int  LAT_W        = 3,
    parameter int  REGLOG2      = $clog2(NREGS),
    parameter int  EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [EXT_COUNT-1:0]    ext_valid,
    input  T                        ent      [EXT_COUNT],
    input  logic [REGLOG2-1:0]      src_a    [EXT_COUNT],
    input  logic [REGLOG2-1:0]      src_b    [EXT_COUNT],
    input  logic [REGLOG2-1:0]      dst      [EXT_COUNT],
    input  logic [EXT_COUNT-1:0]    dst_we,
    input  logic [LAT_W-1:0]        lat      [EXT_COUNT],
    output logic                    ext_enable,
    output logic [EXTCOUNTLOG2-1:0] ext_consumed,
    input  logic                    exec_stall,
    input  logic                    flush,
    output logic [ISSUE_WIDTH-1:0]  iss_valid,
    output T                        iss_ent  [ISSUE_WIDTH]
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0]             stat_issued,
    output logic [31:0]             stat_dep_stall,
    output logic [31:0]             stat_exec_stall
`endif
);

    // Width able to hold an issue count from 0 to ISSUE_WIDTH inclusive.
    localparam int NW = $clog2(ISSUE_WIDTH + 1);

    logic [LAT_W-1:0]       sb_q [NREGS];
    logic [LAT_W-1:0]       sb_d [NREGS];

    logic [ISSUE_WIDTH-1:0] issValid_q;
    logic [ISSUE_WIDTH-1:0] issValid_d;
    T                       issEnt_q [ISSUE_WIDTH];

    logic [ISSUE_WIDTH-1:0] slotWrites;
    logic [ISSUE_WIDTH-1:0] slotReady;
    logic [ISSUE_WIDTH-1:0] laneIssue;
    logic [NW-1:0]          issueCnt;
    logic                   prefixBroken;
    logic                   fire;

    // Per-slot readiness. A slot only ever writes a nonzero register, so a
    // match against an earlier writer's dst can never be a read of r0.
    always_comb begin
        slotWrites = '0;
        slotReady  = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            slotWrites[i] = dst_we[i] && (dst[i] != '0);
        end
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            slotReady[i] = ext_valid[i];
            if ((src_a[i] != '0) && (sb_q[src_a[i]] != '0)) begin
                slotReady[i] = 1'b0;
            end
            if ((src_b[i] != '0) && (sb_q[src_b[i]] != '0)) begin
                slotReady[i] = 1'b0;
            end
            if (slotWrites[i] && (sb_q[dst[i]] != '0)) begin
                slotReady[i] = 1'b0;
            end
            for (int j = 0; j < ISSUE_WIDTH; j++) begin
                if ((j < i) && slotWrites[j] &&
                    ((dst[j] == src_a[i]) || (dst[j] == src_b[i]) ||
                     (slotWrites[i] && (dst[j] == dst[i])))) begin
                    slotReady[i] = 1'b0;
                end
            end
        end
    end

    // Longest ready prefix from slot 0; the first non-ready slot stops the
    // scan so later ready slots never overtake it.
    always_comb begin
        issueCnt     = '0;
        laneIssue    = '0;
        prefixBroken = 1'b0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (!prefixBroken && slotReady[i]) begin
                issueCnt     = issueCnt + NW'(1);
                laneIssue[i] = 1'b1;
            end else begin
                prefixBroken = 1'b1;
            end
        end
    end

    // Extract handshake back to the queue.
    always_comb begin
        fire         = (issueCnt != '0) && !exec_stall && !flush;
        ext_enable   = fire;
        ext_consumed = '0;
        if (fire) begin
            ext_consumed = EXTCOUNTLOG2'(issueCnt - NW'(1));
        end
    end

    // Issue stage valid bits: flush beats stall, stall holds, otherwise the
    // stage takes the new group or goes empty.
    always_comb begin
        issValid_d = issValid_q;
        if (flush) begin
            issValid_d = '0;
        end else if (!exec_stall) begin
            issValid_d = fire ? laneIssue : '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            issValid_q <= '0;
        end else begin
            issValid_q <= issValid_d;
        end
    end

    // Payload needs no reset; it is only meaningful alongside a valid bit.
    always_ff @(posedge clock) begin
        if (fire) begin
            for (int k = 0; k < ISSUE_WIDTH; k++) begin
                issEnt_q[k] <= ent[k];
            end
        end
    end

    // Scoreboard: counters freeze while execute stalls, otherwise count down.
    // A newly issued writer reloads its destination, overriding the countdown.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            sb_d[r] = sb_q[r];
        end
        if (!exec_stall) begin
            for (int r = 0; r < NREGS; r++) begin
                if (sb_q[r] != '0) begin
                    sb_d[r] = sb_q[r] - LAT_W'(1);
                end
            end
            if (fire) begin
                for (int k = 0; k < ISSUE_WIDTH; k++) begin
                    if (laneIssue[k] && slotWrites[k] && (lat[k] != '0)) begin
                        sb_d[dst[k]] = lat[k];
                    end
                end
            end
        end
        sb_d[0] = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                sb_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                sb_q[r] <= sb_d[r];
            end
        end
    end

    assign iss_valid = issValid_q;
    always_comb begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            iss_ent[k] = issEnt_q[k];
        end
    end

`ifdef ISSUE_STATS_EN
    logic [31:0] statIssued_q,    statIssued_d;
    logic [31:0] statDepStall_q,  statDepStall_d;
    logic [31:0] statExecStall_q, statExecStall_d;
    logic [32:0] issuedSum;

    // Saturating event counters; a full counter stays at all-ones.
    always_comb begin
        statIssued_d    = statIssued_q;
        statDepStall_d  = statDepStall_q;
        statExecStall_d = statExecStall_q;
        issuedSum       = {1'b0, statIssued_q} + 33'(issueCnt);
        if (fire) begin
            statIssued_d = issuedSum[32] ? '1 : issuedSum[31:0];
        end
        if (ext_valid[0] && (issueCnt == '0) && !exec_stall &&
            (statDepStall_q != '1)) begin
            statDepStall_d = statDepStall_q + 32'd1;
        end
        if (exec_stall && ext_valid[0] && (statExecStall_q != '1)) begin
            statExecStall_d = statExecStall_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            statIssued_q    <= '0;
            statDepStall_q  <= '0;
            statExecStall_q <= '0;
        end else begin
            statIssued_q    <= statIssued_d;
            statDepStall_q  <= statDepStall_d;
            statExecStall_q <= statExecStall_d;
        end
    end

    assign stat_issued     = statIssued_q;
    assign stat_dep_stall  = statDepStall_q;
    assign stat_exec_stall = statExecStall_q;
`endif

endmodule
